// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared types and constants for the SSD1306 SPI receive model.
//   e_addr_mode    - GDDRAM addressing mode (HORIZ/VERT/PAGE)
//   CMD_*          - addressing command opcodes decoded by the receiver
//   cmd_arg_count  - number of argument bytes that follow a command opcode
package ssd1306_pkg;

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    PAGE  = 2'd2
  } e_addr_mode;

  localparam logic [7:0] CMD_MODE       = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR   = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] CMD_PAGE_START = 8'hB0;

  // Argument bytes following each opcode; 0 for single-byte commands.
  function automatic logic [2:0] cmd_arg_count(input logic [7:0] cmd);
    logic [2:0] n;
    n = 3'd0;
    case (cmd)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: n = 3'd1;
      8'h21, 8'h22, 8'hA3:                                           n = 3'd2;
      8'h29, 8'h2A:                                                  n = 3'd5;
      8'h26, 8'h27:                                                  n = 3'd6;
      default:                                                       n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_byte_deserializer.sv
// spi_byte_deserializer: oversampled SPI slave front end.
//   clk, rst         - oversampling clock, async active-high reset
//   spi_*            - raw link inputs (csn, clk, mosi, dc, rstn)
//   rx_byte, rx_dc   - last received byte and its dc value
//   rx_stb           - one-cycle pulse when rx_byte/rx_dc update
//   panel_rstn       - synchronised panel reset (active low)
//   frame_err        - sticky framing error (only with SSD1306_RX_ERR_EN)
module spi_byte_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_rstn,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_stb,
`ifdef SSD1306_RX_ERR_EN
  output logic       frame_err,
`endif
  output logic       panel_rstn
);

  // Bit order in the synchroniser vectors: {rstn, dc, mosi, sclk, csn}.
  localparam logic [4:0] SyncRst = 5'b00001;

  logic [4:0] sync1_q, sync2_q;
  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] rx_byte_q;
  logic       rx_dc_q, rx_stb_q;

  logic csn_s, sclk_s, mosi_s, dc_s, rstn_s, rise;

  assign csn_s  = sync2_q[0];
  assign sclk_s = sync2_q[1];
  assign mosi_s = sync2_q[2];
  assign dc_s   = sync2_q[3];
  assign rstn_s = sync2_q[4];
  assign rise   = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= SyncRst;
      sync2_q     <= SyncRst;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      rx_byte_q   <= 8'd0;
      rx_dc_q     <= 1'b0;
      rx_stb_q    <= 1'b0;
    end else begin
      sync1_q     <= {spi_rstn, spi_dc, spi_mosi, spi_clk, spi_csn};
      sync2_q     <= sync1_q;
      sclk_prev_q <= sclk_s;
      rx_stb_q    <= 1'b0;
      if (!rstn_s || csn_s) begin
        bit_cnt_q <= 3'd0;
      end else if (rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q <= {shift_q, mosi_s};
          rx_dc_q   <= dc_s;
          rx_stb_q  <= 1'b1;
          bit_cnt_q <= 3'd0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
    end
  end

`ifdef SSD1306_RX_ERR_EN
  logic       csn_prev_q, err_q;
  logic [1:0] gap_q;

  // gap_q counts clk_in cycles since the last detected edge, saturating at 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_prev_q <= 1'b1;
      gap_q      <= 2'd3;
      err_q      <= 1'b0;
    end else begin
      csn_prev_q <= csn_s;
      if (rise)              gap_q <= 2'd0;
      else if (gap_q != 2'd3) gap_q <= gap_q + 2'd1;
      if ((csn_s && !csn_prev_q && bit_cnt_q != 3'd0) || (rise && gap_q == 2'd0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign frame_err = err_q;
`endif

  assign rx_byte    = rx_byte_q;
  assign rx_dc      = rx_dc_q;
  assign rx_stb     = rx_stb_q;
  assign panel_rstn = rstn_s;

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: display-side model of the SSD1306 4-wire SPI link.
// Deserialises bytes, decodes addressing commands and emits GDDRAM writes.
//   clk_in, reset_in           - oversampling clock, async active-high reset
//   spi_*_in                   - raw SPI link (csn, clk, mosi, dc, rstn)
//   byte_out/byte_is_data_out  - last received byte and its dc bit
//   byte_stb_out               - one-cycle pulse per received byte
//   gram_we_out/addr/data      - GDDRAM write port (addr = page*COLS + col)
//   frame_err_out              - sticky framing error, present only when
//                                SSD1306_RX_ERR_EN is defined
module ssd1306_spi_receiver
  import ssd1306_pkg::*;
#(
  parameter int unsigned COLS    = 128,
  parameter int unsigned PAGES   = 8,
  parameter int unsigned GRAM_AW = $clog2(COLS * PAGES)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               spi_csn_in,
  input  logic               spi_clk_in,
  input  logic               spi_mosi_in,
  input  logic               spi_dc_in,
  input  logic               spi_rstn_in,
  output logic [7:0]         byte_out,
  output logic               byte_is_data_out,
  output logic               byte_stb_out,
  output logic               gram_we_out,
  output logic [GRAM_AW-1:0] gram_addr_out,
`ifdef SSD1306_RX_ERR_EN
  output logic               frame_err_out,
`endif
  output logic [7:0]         gram_data_out
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;

  typedef enum logic [0:0] {StIdle, StArgs} dec_state_e;

  logic [7:0] rx_byte;
  logic       rx_dc, rx_stb, panel_rstn;

  spi_byte_deserializer u_deser (
    .clk        (clk_in),
    .rst        (reset_in),
    .spi_csn    (spi_csn_in),
    .spi_clk    (spi_clk_in),
    .spi_mosi   (spi_mosi_in),
    .spi_dc     (spi_dc_in),
    .spi_rstn   (spi_rstn_in),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .rx_stb     (rx_stb),
`ifdef SSD1306_RX_ERR_EN
    .frame_err  (frame_err_out),
`endif
    .panel_rstn (panel_rstn)
  );

  dec_state_e    state_q, state_d;
  logic [2:0]    args_left_q, args_left_d, arg_idx_q, arg_idx_d;
  logic [7:0]    cmd_q, cmd_d;
  e_addr_mode    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          gram_we;
  logic [7:0]    col_ext;

  function automatic logic [CW-1:0] clip_col(input logic [7:0] v);
    return (int'(v) >= COLS) ? CW'(COLS - 1) : CW'(v);
  endfunction

  function automatic logic [PW-1:0] clip_page(input logic [7:0] v);
    return (int'(v) >= PAGES) ? PW'(PAGES - 1) : PW'(v);
  endfunction

  function automatic logic [CW-1:0] inc_col(input logic [CW-1:0] c);
    return (int'(c) >= COLS - 1) ? '0 : c + CW'(1);
  endfunction

  function automatic logic [PW-1:0] inc_page(input logic [PW-1:0] p);
    return (int'(p) >= PAGES - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    args_left_d  = args_left_q;
    arg_idx_d    = arg_idx_q;
    cmd_d        = cmd_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    gram_we      = 1'b0;
    col_ext      = 8'(col_q);

    if (rx_stb) begin
      if (rx_dc) begin
        // Data always lands in GDDRAM; it also abandons any pending arguments.
        gram_we = 1'b1;
        state_d = StIdle;
        unique case (mode_q)
          HORIZ: begin
            if (col_q == col_end_q) begin
              col_d  = col_start_q;
              page_d = (page_q == page_end_q) ? page_start_q : inc_page(page_q);
            end else begin
              col_d = inc_col(col_q);
            end
          end
          VERT: begin
            if (page_q == page_end_q) begin
              page_d = page_start_q;
              col_d  = (col_q == col_end_q) ? col_start_q : inc_col(col_q);
            end else begin
              page_d = inc_page(page_q);
            end
          end
          PAGE:    col_d = inc_col(col_q);
          default: ;
        endcase
      end else if (state_q == StArgs) begin
        args_left_d = args_left_q - 3'd1;
        arg_idx_d   = arg_idx_q + 3'd1;
        if (args_left_q == 3'd1) state_d = StIdle;
        case (cmd_q)
          CMD_MODE: if (rx_byte[1:0] != 2'd3) mode_d = e_addr_mode'(rx_byte[1:0]);
          CMD_COL_ADDR: begin
            if (arg_idx_q == 3'd0) begin
              col_start_d = clip_col(rx_byte);
              col_d       = clip_col(rx_byte);
            end else if (arg_idx_q == 3'd1) begin
              col_end_d = clip_col(rx_byte);
            end
          end
          CMD_PAGE_ADDR: begin
            if (arg_idx_q == 3'd0) begin
              page_start_d = clip_page(rx_byte);
              page_d       = clip_page(rx_byte);
            end else if (arg_idx_q == 3'd1) begin
              page_end_d = clip_page(rx_byte);
            end
          end
          default: ;
        endcase
      end else if (cmd_arg_count(rx_byte) != 3'd0) begin
        state_d     = StArgs;
        args_left_d = cmd_arg_count(rx_byte);
        arg_idx_d   = 3'd0;
        cmd_d       = rx_byte;
      end else if (rx_byte[7:4] == 4'h0) begin
        // Nibble writes build an 8-bit column that wraps modulo COLS.
        if (mode_q == PAGE) col_d = CW'(int'({col_ext[7:4], rx_byte[3:0]}) % COLS);
      end else if (rx_byte[7:4] == 4'h1) begin
        if (mode_q == PAGE) col_d = CW'(int'({rx_byte[3:0], col_ext[3:0]}) % COLS);
      end else if (rx_byte[7:4] == CMD_PAGE_START[7:4] && int'(rx_byte[3:0]) < PAGES) begin
        page_d = PW'(rx_byte[3:0]);
      end
    end

    // Panel reset holds the decoder at its reset state and blocks writes.
    if (!panel_rstn) begin
      state_d      = StIdle;
      args_left_d  = 3'd0;
      arg_idx_d    = 3'd0;
      cmd_d        = 8'd0;
      mode_d       = PAGE;
      col_d        = '0;
      col_start_d  = '0;
      col_end_d    = CW'(COLS - 1);
      page_d       = '0;
      page_start_d = '0;
      page_end_d   = PW'(PAGES - 1);
      gram_we      = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      args_left_q  <= 3'd0;
      arg_idx_q    <= 3'd0;
      cmd_q        <= 8'd0;
      mode_q       <= PAGE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
    end else begin
      state_q      <= state_d;
      args_left_q  <= args_left_d;
      arg_idx_q    <= arg_idx_d;
      cmd_q        <= cmd_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign byte_out         = rx_byte;
  assign byte_is_data_out = rx_dc;
  assign byte_stb_out     = rx_stb;
  assign gram_we_out      = gram_we;
  assign gram_data_out    = rx_byte;
  assign gram_addr_out    = GRAM_AW'(page_q) * GRAM_AW'(COLS) + GRAM_AW'(col_q);

endmodule
